// File: rtl/mips_pipe_cpu.sv
// Five-stage in-order MIPS-subset core (IF, ID, EX, MEM, WB) with internal memories.
// There is no hazard detection or forwarding; dependent code must be spaced with NOPs.
package mips_pipe_pkg;
    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_op_e;
endpackage

module mips_if_stage #(
    parameter int IM_WORDS = 128
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        load_en,
    input  logic [$clog2(IM_WORDS)-1:0] load_addr,
    input  logic [31:0]                 load_data,
    output logic [31:0]                 instr,
    output logic [31:0]                 pc_plus4
);
    localparam int IA_W = $clog2(IM_WORDS);

    logic [31:0] instruction [0:IM_WORDS-1];
    logic [31:0] PC;

    assign pc_plus4 = PC + 32'd4;
    assign instr    = instruction[PC[IA_W+1:2]];

    // Program counter advances one word per cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            PC <= 32'd0;
        end else begin
            PC <= pc_plus4;
        end
    end

    // Optional write port; programs normally arrive through the backdoor
    always_ff @(posedge clk) begin
        if (load_en) begin
            instruction[load_addr] <= load_data;
        end
    end
endmodule

module mips_id_stage (
    input  logic                   clk,
    input  logic [31:0]            instr,
    input  logic                   wb_we,
    input  logic [4:0]             wb_dst,
    input  logic [31:0]            wb_data,
    output logic [31:0]            rs_val,
    output logic [31:0]            rt_val,
    output logic [31:0]            imm_ext,
    output logic                   reg_we,
    output logic                   mem_we,
    output logic                   mem_rd,
    output logic                   alu_imm,
    output mips_pipe_pkg::alu_op_e alu_op,
    output logic [4:0]             dest
);
    import mips_pipe_pkg::*;

    logic [31:0] REG [0:31];
    logic [5:0]  op_s;
    logic [5:0]  funct_s;
    logic [4:0]  rs_s;
    logic [4:0]  rt_s;
    logic [4:0]  rd_s;
    logic        wb_live_s;

    function automatic logic [31:0] sign_ext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    assign op_s      = instr[31:26];
    assign rs_s      = instr[25:21];
    assign rt_s      = instr[20:16];
    assign rd_s      = instr[15:11];
    assign funct_s   = instr[5:0];
    assign imm_ext   = sign_ext16(instr[15:0]);
    assign wb_live_s = wb_we && (wb_dst != 5'd0);

    // Register read with write-through from the WB stage; $0 always reads zero
    always_comb begin
        rs_val = REG[rs_s];
        rt_val = REG[rt_s];
        if (rs_s == 5'd0) begin
            rs_val = 32'd0;
        end else if (wb_live_s && (wb_dst == rs_s)) begin
            rs_val = wb_data;
        end else begin
            rs_val = REG[rs_s];
        end
        if (rt_s == 5'd0) begin
            rt_val = 32'd0;
        end else if (wb_live_s && (wb_dst == rt_s)) begin
            rt_val = wb_data;
        end else begin
            rt_val = REG[rt_s];
        end
    end

    // Decode; anything unrecognised (including unknown bits) stays a NOP
    always_comb begin
        reg_we  = 1'b0;
        mem_we  = 1'b0;
        mem_rd  = 1'b0;
        alu_imm = 1'b0;
        alu_op  = ALU_ADD;
        dest    = 5'd0;
        case (op_s)
            6'b000000: begin
                dest = rd_s;
                case (funct_s)
                    6'b100000: begin reg_we = 1'b1; alu_op = ALU_ADD; end
                    6'b100010: begin reg_we = 1'b1; alu_op = ALU_SUB; end
                    6'b100100: begin reg_we = 1'b1; alu_op = ALU_AND; end
                    6'b100101: begin reg_we = 1'b1; alu_op = ALU_OR;  end
                    6'b101010: begin reg_we = 1'b1; alu_op = ALU_SLT; end
                    default:   begin reg_we = 1'b0; alu_op = ALU_ADD; end
                endcase
            end
            6'b001000: begin
                reg_we  = 1'b1;
                alu_imm = 1'b1;
                dest    = rt_s;
            end
            6'b100011: begin
                reg_we  = 1'b1;
                mem_rd  = 1'b1;
                alu_imm = 1'b1;
                dest    = rt_s;
            end
            6'b101011: begin
                mem_we  = 1'b1;
                alu_imm = 1'b1;
            end
            default: begin
                reg_we = 1'b0;
                mem_we = 1'b0;
            end
        endcase
    end

    // Register file is not reset; it keeps backdoor-loaded contents
    always_ff @(posedge clk) begin
        if (wb_live_s) begin
            REG[wb_dst] <= wb_data;
        end
    end
endmodule

module mips_mem_stage #(
    parameter int DM_WORDS = 128
) (
    input  logic                        clk,
    input  logic                        we,
    input  logic [$clog2(DM_WORDS)-1:0] addr,
    input  logic [31:0]                 wdata,
    output logic [31:0]                 rdata
);
    logic [31:0] DM [0:DM_WORDS-1];

    assign rdata = DM[addr];

    // Store commits on the edge that closes the MEM stage
    always_ff @(posedge clk) begin
        if (we) begin
            DM[addr] <= wdata;
        end
    end
endmodule

module mips_pipe_cpu #(
    parameter int IM_WORDS = 128,
    parameter int DM_WORDS = 128
) (
    input logic clk,
    input logic rst
);
    import mips_pipe_pkg::*;

    localparam int IA_W = $clog2(IM_WORDS);
    localparam int DA_W = $clog2(DM_WORDS);

    logic [31:0] if_instr_s;
    logic [31:0] if_pc4_s;
    logic [31:0] fd_instr_r;
    logic [31:0] FD_PC;

    logic [31:0] id_rs_val_s;
    logic [31:0] id_rt_val_s;
    logic [31:0] id_imm_s;
    logic        id_reg_we_s;
    logic        id_mem_we_s;
    logic        id_mem_rd_s;
    logic        id_alu_imm_s;
    alu_op_e     id_alu_op_s;
    logic [4:0]  id_dest_s;

    logic [31:0] de_rs_val_r;
    logic [31:0] de_rt_val_r;
    logic [31:0] de_imm_r;
    logic        de_reg_we_r;
    logic        de_mem_we_r;
    logic        de_mem_rd_r;
    logic        de_alu_imm_r;
    alu_op_e     de_alu_op_r;
    logic [4:0]  de_dest_r;

    logic [31:0] ex_op_b_s;
    logic [31:0] ex_result_s;

    logic [31:0] em_alu_r;
    logic [31:0] em_rt_val_r;
    logic        em_reg_we_r;
    logic        em_mem_we_r;
    logic        em_mem_rd_r;
    logic [4:0]  em_dest_r;

    logic [31:0] mem_rdata_s;

    logic [31:0] mw_data_r;
    logic        mw_reg_we_r;
    logic [4:0]  mw_dest_r;

    logic        unused_fd_pc_s;

    // PC+4 of the decoding instruction is kept for observation only
    assign unused_fd_pc_s = ^FD_PC;

    mips_if_stage #(.IM_WORDS(IM_WORDS)) IF (
        .clk       (clk),
        .rst       (rst),
        .load_en   (1'b0),
        .load_addr ({IA_W{1'b0}}),
        .load_data (32'd0),
        .instr     (if_instr_s),
        .pc_plus4  (if_pc4_s)
    );

    mips_id_stage ID (
        .clk     (clk),
        .instr   (fd_instr_r),
        .wb_we   (mw_reg_we_r),
        .wb_dst  (mw_dest_r),
        .wb_data (mw_data_r),
        .rs_val  (id_rs_val_s),
        .rt_val  (id_rt_val_s),
        .imm_ext (id_imm_s),
        .reg_we  (id_reg_we_s),
        .mem_we  (id_mem_we_s),
        .mem_rd  (id_mem_rd_s),
        .alu_imm (id_alu_imm_s),
        .alu_op  (id_alu_op_s),
        .dest    (id_dest_s)
    );

    mips_mem_stage #(.DM_WORDS(DM_WORDS)) MEM (
        .clk   (clk),
        .we    (em_mem_we_r),
        .addr  (em_alu_r[DA_W-1:0]),
        .wdata (em_rt_val_r),
        .rdata (mem_rdata_s)
    );

    // IF/ID pipeline register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fd_instr_r <= 32'd0;
            FD_PC      <= 32'd0;
        end else begin
            fd_instr_r <= if_instr_s;
            FD_PC      <= if_pc4_s;
        end
    end

    // ID/EX pipeline register; cleared control behaves as a NOP
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            de_rs_val_r  <= 32'd0;
            de_rt_val_r  <= 32'd0;
            de_imm_r     <= 32'd0;
            de_reg_we_r  <= 1'b0;
            de_mem_we_r  <= 1'b0;
            de_mem_rd_r  <= 1'b0;
            de_alu_imm_r <= 1'b0;
            de_alu_op_r  <= ALU_ADD;
            de_dest_r    <= 5'd0;
        end else begin
            de_rs_val_r  <= id_rs_val_s;
            de_rt_val_r  <= id_rt_val_s;
            de_imm_r     <= id_imm_s;
            de_reg_we_r  <= id_reg_we_s;
            de_mem_we_r  <= id_mem_we_s;
            de_mem_rd_r  <= id_mem_rd_s;
            de_alu_imm_r <= id_alu_imm_s;
            de_alu_op_r  <= id_alu_op_s;
            de_dest_r    <= id_dest_s;
        end
    end

    // EX-stage ALU, wrap-around arithmetic and signed set-less-than
    always_comb begin
        ex_op_b_s   = de_rt_val_r;
        ex_result_s = 32'd0;
        if (de_alu_imm_r) begin
            ex_op_b_s = de_imm_r;
        end else begin
            ex_op_b_s = de_rt_val_r;
        end
        case (de_alu_op_r)
            ALU_ADD: ex_result_s = de_rs_val_r + ex_op_b_s;
            ALU_SUB: ex_result_s = de_rs_val_r - ex_op_b_s;
            ALU_AND: ex_result_s = de_rs_val_r & ex_op_b_s;
            ALU_OR:  ex_result_s = de_rs_val_r | ex_op_b_s;
            ALU_SLT: ex_result_s = {31'd0, ($signed(de_rs_val_r) < $signed(ex_op_b_s))};
            default: ex_result_s = de_rs_val_r + ex_op_b_s;
        endcase
    end

    // EX/MEM pipeline register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            em_alu_r    <= 32'd0;
            em_rt_val_r <= 32'd0;
            em_reg_we_r <= 1'b0;
            em_mem_we_r <= 1'b0;
            em_mem_rd_r <= 1'b0;
            em_dest_r   <= 5'd0;
        end else begin
            em_alu_r    <= ex_result_s;
            em_rt_val_r <= de_rt_val_r;
            em_reg_we_r <= de_reg_we_r;
            em_mem_we_r <= de_mem_we_r;
            em_mem_rd_r <= de_mem_rd_r;
            em_dest_r   <= de_dest_r;
        end
    end

    // MEM/WB pipeline register selects load data or ALU result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mw_data_r   <= 32'd0;
            mw_reg_we_r <= 1'b0;
            mw_dest_r   <= 5'd0;
        end else begin
            if (em_mem_rd_r) begin
                mw_data_r <= mem_rdata_s;
            end else begin
                mw_data_r <= em_alu_r;
            end
            mw_reg_we_r <= em_reg_we_r;
            mw_dest_r   <= em_dest_r;
        end
    end
endmodule

// File: tb/tb_mips_pipe_cpu.sv
// Self-checking bench for mips_pipe_cpu: directed vectors, hand sequences and
// randomized NOP-spaced programs compared against an instruction-level model.
module tb_mips_pipe_cpu;
    localparam int IMW = 128;
    localparam int DMW = 128;

    logic clk;
    logic rst;

    int n_checks;
    int n_fail;

    logic [31:0] prog [0:IMW-1];
    logic [31:0] m_reg [0:31];
    logic [31:0] m_dm  [0:DMW-1];

    typedef enum int {K_ADD, K_SUB, K_AND, K_OR, K_SLT, K_ADDI, K_LW, K_SW, K_BAD} kind_e;

    typedef struct {
        kind_e       kind;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [15:0] imm;
        logic [31:0] word;
    } rinstr_t;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] instr;
        logic [4:0]  dst;
        logic [31:0] exp;
    } alu_vec_t;

    rinstr_t  rp [0:19];
    alu_vec_t vecs [0:11];

    mips_pipe_cpu #(.IM_WORDS(IMW), .DM_WORDS(DMW)) dut (
        .clk (clk),
        .rst (rst)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    function automatic logic [31:0] rtype(input logic [5:0] funct, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd);
        return {6'b000000, rs, rt, rd, 5'd0, funct};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Backdoor loads use nonblocking writes so they never race the design's own writes
    task automatic load_all();
        for (int i = 0; i < IMW; i++) dut.IF.instruction[i] <= prog[i];
        for (int i = 0; i < 32; i++)  dut.ID.REG[i] <= m_reg[i];
        for (int i = 0; i < DMW; i++) dut.MEM.DM[i] <= m_dm[i];
        #1;
    endtask

    task automatic enter_reset();
        @(posedge clk);
        #2 rst = 1'b1;
    endtask

    task automatic leave_reset();
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic clear_state();
        for (int i = 0; i < IMW; i++) prog[i] = 32'd0;
        for (int i = 0; i < 32; i++)  m_reg[i] = 32'd0;
        for (int i = 0; i < DMW; i++) m_dm[i] = 32'd0;
    endtask

    task automatic compare_state(input string tag);
        for (int i = 0; i < 32; i++)  check($sformatf("%s_reg%0d", tag, i), dut.ID.REG[i], m_reg[i]);
        for (int i = 0; i < DMW; i++) check($sformatf("%s_dm%0d", tag, i), dut.MEM.DM[i], m_dm[i]);
    endtask

    task automatic load_plan();
        clear_state();
        m_dm[0]  = 32'd9;
        m_dm[1]  = 32'd3;
        m_reg[1] = 32'd1;
        m_reg[2] = 32'd2;
        prog[0]  = itype(6'b100011, 5'd0, 5'd3, 16'd0);
        prog[5]  = rtype(6'b100000, 5'd2, 5'd3, 5'd3);
        prog[10] = itype(6'b101011, 5'd1, 5'd3, 16'd0);
        load_all();
    endtask

    // Instruction-level reference: execute the program in order, one instruction at a time
    task automatic model_exec(input rinstr_t ins);
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] se;
        int          idx;
        a   = m_reg[ins.rs];
        b   = m_reg[ins.rt];
        se  = {{16{ins.imm[15]}}, ins.imm};
        idx = int'((a + se) % 32'd128);
        case (ins.kind)
            K_ADD:  if (ins.rd != 5'd0) m_reg[ins.rd] = a + b;
            K_SUB:  if (ins.rd != 5'd0) m_reg[ins.rd] = a - b;
            K_AND:  if (ins.rd != 5'd0) m_reg[ins.rd] = a & b;
            K_OR:   if (ins.rd != 5'd0) m_reg[ins.rd] = a | b;
            K_SLT:  if (ins.rd != 5'd0) m_reg[ins.rd] = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            K_ADDI: if (ins.rt != 5'd0) m_reg[ins.rt] = a + se;
            K_LW:   if (ins.rt != 5'd0) m_reg[ins.rt] = m_dm[idx];
            K_SW:   m_dm[idx] = b;
            default: ;
        endcase
    endtask

    function automatic rinstr_t rand_instr();
        rinstr_t r;
        logic [5:0] op;
        logic [5:0] fn;
        r.kind = kind_e'($urandom_range(0, 8));
        r.rs   = 5'($urandom_range(0, 31));
        r.rt   = 5'($urandom_range(0, 31));
        r.rd   = 5'($urandom_range(0, 31));
        r.imm  = 16'($urandom);
        case (r.kind)
            K_ADD:  r.word = rtype(6'b100000, r.rs, r.rt, r.rd);
            K_SUB:  r.word = rtype(6'b100010, r.rs, r.rt, r.rd);
            K_AND:  r.word = rtype(6'b100100, r.rs, r.rt, r.rd);
            K_OR:   r.word = rtype(6'b100101, r.rs, r.rt, r.rd);
            K_SLT:  r.word = rtype(6'b101010, r.rs, r.rt, r.rd);
            K_ADDI: r.word = itype(6'b001000, r.rs, r.rt, r.imm);
            K_LW:   r.word = itype(6'b100011, r.rs, r.rt, r.imm);
            K_SW:   r.word = itype(6'b101011, r.rs, r.rt, r.imm);
            default: begin
                if ($urandom_range(0, 1) == 0) begin
                    do fn = 6'($urandom);
                    while (fn == 6'b100000 || fn == 6'b100010 || fn == 6'b100100 ||
                           fn == 6'b100101 || fn == 6'b101010);
                    r.word = rtype(fn, r.rs, r.rt, r.rd);
                end else begin
                    do op = 6'($urandom);
                    while (op == 6'b000000 || op == 6'b001000 || op == 6'b100011 || op == 6'b101011);
                    r.word = itype(op, r.rs, r.rt, r.imm);
                end
            end
        endcase
        return r;
    endfunction

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;

        vecs[0]  = '{"add",       32'd5,          32'd7, rtype(6'b100000, 5'd1, 5'd2, 5'd3), 5'd3, 32'd12};
        vecs[1]  = '{"sub",       32'd5,          32'd7, rtype(6'b100010, 5'd1, 5'd2, 5'd4), 5'd4, 32'hfffffffe};
        vecs[2]  = '{"and",       32'd5,          32'd7, rtype(6'b100100, 5'd1, 5'd2, 5'd4), 5'd4, 32'd5};
        vecs[3]  = '{"or",        32'd5,          32'd7, rtype(6'b100101, 5'd1, 5'd2, 5'd4), 5'd4, 32'd7};
        vecs[4]  = '{"slt_lt",    32'd5,          32'd7, rtype(6'b101010, 5'd1, 5'd2, 5'd5), 5'd5, 32'd1};
        vecs[5]  = '{"slt_ge",    32'd5,          32'd7, rtype(6'b101010, 5'd2, 5'd1, 5'd5), 5'd5, 32'd0};
        vecs[6]  = '{"slt_neg",   32'hffffffff,   32'd1, rtype(6'b101010, 5'd1, 5'd2, 5'd5), 5'd5, 32'd1};
        vecs[7]  = '{"addi_m1",   32'd5,          32'd7, itype(6'b001000, 5'd1, 5'd6, 16'hffff), 5'd6, 32'd4};
        vecs[8]  = '{"add_r0",    32'd5,          32'd7, rtype(6'b100000, 5'd1, 5'd2, 5'd0), 5'd0, 32'd0};
        vecs[9]  = '{"add_wrap",  32'h7fffffff,   32'd1, rtype(6'b100000, 5'd1, 5'd2, 5'd3), 5'd3, 32'h80000000};
        vecs[10] = '{"bad_op",    32'd5,          32'd7, itype(6'b111111, 5'd1, 5'd7, 16'd3), 5'd7, 32'd0};
        vecs[11] = '{"bad_funct", 32'd5,          32'd7, rtype(6'b000001, 5'd1, 5'd2, 5'd8), 5'd8, 32'd0};

        // Directed program, reset released at 12 ns
        load_plan();
        #(12 - $time) rst = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            step();
            check($sformatf("fd_pc_e%0d", k), dut.FD_PC, 32'(4 * k));
            if (k == 5)  check("plan_lw_reg3", dut.ID.REG[3], 32'd9);
            if (k == 10) check("plan_add_reg3", dut.ID.REG[3], 32'h0000000b);
        end
        check("plan_sw_dm1", dut.MEM.DM[1], 32'h0000000b);
        check("plan_dm0_kept", dut.MEM.DM[0], 32'd9);

        // Mid-program reset squashes in-flight work and restarts from index 0
        enter_reset();
        load_plan();
        leave_reset();
        for (int k = 0; k < 7; k++) step();
        check("pre_rst_reg3", dut.ID.REG[3], 32'd9);
        #1 rst = 1'b1;
        #1;
        check("rst_pc", dut.IF.PC, 32'd0);
        check("rst_fd_pc", dut.FD_PC, 32'd0);
        check("rst_fd_instr", dut.fd_instr_r, 32'd0);
        check("rst_de_we", {31'd0, dut.de_reg_we_r}, 32'd0);
        check("rst_em_mem_we", {31'd0, dut.em_mem_we_r}, 32'd0);
        check("rst_mw_we", {31'd0, dut.mw_reg_we_r}, 32'd0);
        check("rst_reg3_kept", dut.ID.REG[3], 32'd9);
        check("rst_dm0_kept", dut.MEM.DM[0], 32'd9);
        dut.MEM.DM[0] <= 32'd20;
        leave_reset();
        for (int k = 1; k <= 14; k++) begin
            step();
            if (k == 1) check("restart_fd_pc", dut.FD_PC, 32'd4);
            if (k == 5) check("restart_lw_reg3", dut.ID.REG[3], 32'd20);
        end
        check("restart_add_reg3", dut.ID.REG[3], 32'd22);
        check("restart_sw_dm1", dut.MEM.DM[1], 32'd22);

        // Single-instruction ALU vectors
        for (int v = 0; v < 12; v++) begin
            enter_reset();
            clear_state();
            m_reg[1] = vecs[v].a;
            m_reg[2] = vecs[v].b;
            prog[0]  = vecs[v].instr;
            load_all();
            leave_reset();
            for (int k = 0; k < 6; k++) step();
            check(vecs[v].name, dut.ID.REG[vecs[v].dst], vecs[v].exp);
        end

        // Unknown and uninitialized instruction words leave all state untouched
        enter_reset();
        clear_state();
        for (int i = 0; i < 32; i++)  m_reg[i] = (i == 0) ? 32'd0 : $urandom;
        for (int i = 0; i < DMW; i++) m_dm[i] = $urandom;
        for (int i = 0; i < IMW; i++) prog[i] = 32'bx;
        prog[0] = 32'hffffffff;
        prog[1] = itype(6'b111110, 5'd1, 5'd2, 16'd5);
        prog[2] = rtype(6'b111111, 5'd1, 5'd2, 5'd3);
        load_all();
        leave_reset();
        for (int k = 0; k < 8; k++) step();
        compare_state("nop");

        // Random NOP-spaced programs against the instruction-level model
        for (int it = 0; it < 8; it++) begin
            enter_reset();
            clear_state();
            for (int i = 1; i < 32; i++)  m_reg[i] = $urandom;
            for (int i = 0; i < DMW; i++) m_dm[i] = $urandom;
            for (int i = 0; i < 20; i++) begin
                rp[i] = rand_instr();
                prog[4 * i] = rp[i].word;
            end
            load_all();
            for (int i = 0; i < 20; i++) model_exec(rp[i]);
            leave_reset();
            for (int k = 0; k < 84; k++) step();
            compare_state($sformatf("rnd%0d", it));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
